// File: rtl/serial_adder_pkg.sv
// Shared state encodings and default operand width for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_8bit_full_adder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha_ab (.a(a),  .b(b),  .s(s1), .c(c1));
    half_adder u_ha_ci (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder, one operand bit per clock, with a valid/ready handshake on both sides.
// Optional overflow output is enabled by defining SA_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair; SA_in_ready high
// SHIFT | adding one bit per edge, LSB first
// DONE  | result held on SA_sum/SA_cout until SA_out_ready
import serial_adder_pkg::*;

module serial_adder_8bit #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             SA_clk,
    input  logic             SA_rst,
    input  logic             SA_in_valid,
    output logic             SA_in_ready,
    input  logic [WIDTH-1:0] SA_in1,
    input  logic [WIDTH-1:0] SA_in2,
    input  logic             SA_cin,
    output logic             SA_out_valid,
    input  logic             SA_out_ready,
    output logic [WIDTH-1:0] SA_sum,
    output logic             SA_busy,
`ifdef SA_OVERFLOW_EN
    output logic             SA_cout,
    output logic             SA_ovf
`else
    output logic             SA_cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign SA_in_ready = (state == IDLE);
    assign SA_busy     = (state != IDLE);

    always_ff @(posedge SA_clk) begin
        if (SA_rst) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            carry_q      <= 1'b0;
            cnt          <= '0;
            SA_out_valid <= 1'b0;
            SA_sum       <= '0;
            SA_cout      <= 1'b0;
`ifdef SA_OVERFLOW_EN
            SA_ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (SA_in_valid) begin
                        a_sr    <= SA_in1;
                        b_sr    <= SA_in2;
                        carry_q <= SA_cin;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the last bit lands the word in place.
                    SA_sum  <= {fa_s, SA_sum[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        SA_cout      <= fa_co;
`ifdef SA_OVERFLOW_EN
                        // carry_q is the carry into the MSB on this edge
                        SA_ovf       <= carry_q ^ fa_co;
`endif
                        SA_out_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (SA_out_ready) begin
                        SA_out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Directed self-checking bench for serial_adder_8bit (WIDTH=8); checks SA_ovf when SA_OVERFLOW_EN is defined.
module tb_serial_adder_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
`ifdef SA_OVERFLOW_EN
    logic       ovf;
`endif

    int checks = 0;
    int failures = 0;

    serial_adder_8bit #(.WIDTH(8)) dut (
        .SA_clk       (clk),
        .SA_rst       (rst),
        .SA_in_valid  (in_valid),
        .SA_in_ready  (in_ready),
        .SA_in1       (in1),
        .SA_in2       (in2),
        .SA_cin       (cin),
        .SA_out_valid (out_valid),
        .SA_out_ready (out_ready),
        .SA_sum       (sum),
        .SA_busy      (busy),
`ifdef SA_OVERFLOW_EN
        .SA_cout      (cout),
        .SA_ovf       (ovf)
`else
        .SA_cout      (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
        in1 = a;
        in2 = b;
        cin = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        accept(a, b, c);
        check({tag, "_busy"}, busy, 1);
        wait_result(tag, 8);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
`ifdef SA_OVERFLOW_EN
        check({tag, "_ovf"}, ovf, exp_ovf);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_sum_held"}, sum, exp_sum);
        check({tag, "_idle_cout_held"}, cout, exp_cout);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        cin = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;

        do_op("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("cin",    8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        do_op("wrap",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("sovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("negovf", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        do_op("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Hold in DONE with consumer stalled; new operands must be ignored.
        accept(8'h3C, 8'h0F, 1'b0);
        wait_result("hold", 8);
        in1 = 8'hAA;
        in2 = 8'hAA;
        cin = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", sum, 8'h4B);
            check("hold_cout", cout, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_no_accept_busy", busy, 0);
        check("release_in_ready", in_ready, 1);
        check("release_sum_held", sum, 8'h4B);
        in_valid = 1'b0;

        // Reset on the 4th SHIFT edge aborts the operation.
        accept(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_no_result", out_valid, 0);
        do_op("post_abort", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Reset wins over a simultaneous handshake.
        in1 = 8'h01;
        in2 = 8'h01;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("rst_prio_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (legal range 2..32).
REQ-002 SHALL have port SA_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port SA_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port SA_in_valid  input  1  operand pair present.
REQ-005 SHALL have port SA_in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports SA_in1 and SA_in2  input  WIDTH  addend operands.
REQ-007 SHALL have port SA_cin  input  1  carry-in, sampled with operands.
REQ-008 SHALL have port SA_out_valid  output  1  result present.
REQ-009 SHALL have port SA_out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port SA_sum  output  WIDTH  registered sum.
REQ-011 SHALL have port SA_cout  output  1  registered carry-out.
REQ-012 SHALL have port SA_busy  output  1  high while state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; SA_in_ready = (state==IDLE).
REQ-014 SHALL accept on an edge where IDLE and SA_in_valid: latch SA_in1/SA_in2 into shift registers, carry FF <= SA_cin, bit counter <= 0, go to SHIFT.
REQ-015 SHALL, per SHIFT edge, add operand LSBs plus carry FF in one full adder, shift the sum bit into the sum register MSB, shift operands right, update carry FF, increment counter.
REQ-016 SHALL go SHIFT->DONE on the edge processing bit WIDTH-1; SA_out_valid is therefore high exactly WIDTH edges after the accepting edge.
REQ-017 SHALL, in DONE, hold SA_out_valid, SA_sum, SA_cout stable until SA_out_ready is high on an edge, then go to IDLE.
REQ-018 SHALL NOT accept new operands in the same edge that releases DONE; minimum period per operation is WIDTH+2 cycles.
REQ-019 SHALL ignore SA_in_valid, SA_in1, SA_in2, SA_cin while in SHIFT or DONE.
REQ-020 SHALL produce SA_sum = (SA_in1+SA_in2+SA_cin) mod 2^WIDTH and SA_cout = bit WIDTH of that sum.
REQ-021 SHALL keep SA_sum/SA_cout at their last value in IDLE after a completed handshake.

Reset
REQ-022 SHALL, on any edge with SA_rst high, force IDLE, SA_out_valid=0, SA_sum=0, SA_cout=0, carry FF=0, counter=0, regardless of state.
REQ-023 SHALL abort an in-progress SHIFT or DONE on reset with no result delivered; SA_in_ready high on the first edge after SA_rst deasserts.
REQ-024 SHALL give SA_rst priority over the input handshake on the same edge.

Configuration
REQ-025 SHALL, when macro SA_OVERFLOW_EN is defined, add output SA_ovf (1 bit) = carry into MSB XOR carry out of MSB, registered and held like SA_sum, reset to 0.
REQ-026 SHALL, without SA_OVERFLOW_EN, have no SA_ovf port and no associated logic.

Structure
REQ-027 SHALL place state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH in shared package/include serial_adder_pkg.
REQ-028 SHALL instantiate one sub-module full_adder (built from two half_adder instances plus OR) for the per-bit addition.
REQ-029 SHALL size the bit counter as clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-030 SHALL check 0x00+0x00, cin=0 -> SA_sum=0x00, SA_cout=0, SA_out_valid exactly 8 edges after accept.
REQ-031 SHALL check 0x12+0x34, cin=1 -> SA_sum=0x47, SA_cout=0.
REQ-032 SHALL check 0xFF+0x01, cin=0 -> SA_sum=0x00, SA_cout=1, SA_ovf=0 (with SA_OVERFLOW_EN).
REQ-033 SHALL check 0x7F+0x01, cin=0 -> SA_sum=0x80, SA_cout=0, SA_ovf=1 (with SA_OVERFLOW_EN).
REQ-034 SHALL check SA_out_ready held low 5 cycles in DONE -> SA_sum/SA_cout stable, SA_in_ready=0, new SA_in_valid ignored.
REQ-035 SHALL check SA_rst pulsed on 4th SHIFT edge -> next cycle IDLE, outputs 0, following 0xA5+0x5A cin=0 -> 0xFF, SA_cout=0.
